spi_ram_arbiter: RTL

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

---
 rtl/spi_ram_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_arbiter.sv
// Arbitrates one single-port RAM between an SPI command stream and a host port.
// Optional macro ARB_SPI_PRIORITY_EN makes SPI win every tie instead of round-robin.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic [7:0]           host_rdata,
  output logic                 host_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  output logic                 spi_ovf
);

  // Handshakes: rx_valid, tx_valid and host_rvalid are single-cycle pulses with no
  // back-pressure; host_req is held until the one-cycle host_gnt, then may drop.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPI_ACC  = 2'd1,
    HOST_ACC = 2'd2,
    RD_WAIT  = 2'd3
  } state_t;

  localparam logic [ADDR_SIZE-1:0] ADDR_MASK = ADDR_SIZE'(MEM_DEPTH - 1);

`ifdef ARB_SPI_PRIORITY_EN
  localparam logic SPI_FIXED_PRIO = 1'b1;
`else
  localparam logic SPI_FIXED_PRIO = 1'b0;
`endif

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                 pend_q, pend_d, pend_we_q, pend_we_d;
  logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]           pend_wdata_q, pend_wdata_d;
  logic                 acc_we_q, acc_we_d;
  logic [ADDR_SIZE-1:0] acc_addr_q, acc_addr_d;
  logic [7:0]           acc_wdata_q, acc_wdata_d;
  logic                 owner_spi_q, owner_spi_d;
  logic                 last_spi_q, last_spi_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           tx_data_q, tx_data_d, host_rdata_q, host_rdata_d;
  logic                 tx_valid_q, tx_valid_d, host_rvalid_q, host_rvalid_d;
  logic                 spi_grant, host_grant;

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    pend_d        = pend_q;
    pend_we_d     = pend_we_q;
    pend_addr_d   = pend_addr_q;
    pend_wdata_d  = pend_wdata_q;
    acc_we_d      = acc_we_q;
    acc_addr_d    = acc_addr_q;
    acc_wdata_d   = acc_wdata_q;
    owner_spi_d   = owner_spi_q;
    last_spi_d    = last_spi_q;
    ovf_d         = ovf_q;
    tx_data_d     = tx_data_q;
    host_rdata_d  = host_rdata_q;
    tx_valid_d    = 1'b0;
    host_rvalid_d = 1'b0;
    spi_grant     = 1'b0;
    host_grant    = 1'b0;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = acc_addr_q & ADDR_MASK;
    ram_wdata     = acc_wdata_q;
    host_gnt      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q && host_req) begin
          if (SPI_FIXED_PRIO || !last_spi_q) spi_grant = 1'b1;
          else                               host_grant = 1'b1;
        end else if (pend_q) begin
          spi_grant = 1'b1;
        end else if (host_req) begin
          host_grant = 1'b1;
        end
        if (spi_grant) begin
          state_d     = SPI_ACC;
          acc_we_d    = pend_we_q;
          acc_addr_d  = pend_addr_q;
          acc_wdata_d = pend_wdata_q;
          owner_spi_d = 1'b1;
          last_spi_d  = 1'b1;
        end
        if (host_grant) begin
          state_d     = HOST_ACC;
          acc_we_d    = host_we;
          acc_addr_d  = host_addr;
          acc_wdata_d = host_wdata;
          owner_spi_d = 1'b0;
          last_spi_d  = 1'b0;
        end
      end
      SPI_ACC, HOST_ACC: begin
        ram_en   = 1'b1;
        ram_we   = acc_we_q;
        host_gnt = (state_q == HOST_ACC);
        state_d  = acc_we_q ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        if (owner_spi_q) begin
          tx_data_d  = ram_rdata;
          tx_valid_d = 1'b1;
        end else begin
          host_rdata_d  = ram_rdata;
          host_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A grant frees the pending slot, so a data command in that same cycle is accepted.
    if (spi_grant) pend_d = 1'b0;
    if (rx_valid) begin
      case (rx_data[9:8])
        2'b00: wr_addr_d = ADDR_SIZE'(rx_data[7:0]);
        2'b10: rd_addr_d = ADDR_SIZE'(rx_data[7:0]);
        default: begin
          if (pend_q && !spi_grant) begin
            ovf_d = 1'b1;
          end else begin
            pend_d       = 1'b1;
            pend_we_d    = ~rx_data[9];
            pend_addr_d  = rx_data[9] ? rd_addr_q : wr_addr_q;
            pend_wdata_d = rx_data[7:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      pend_q        <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_wdata_q  <= '0;
      acc_we_q      <= 1'b0;
      acc_addr_q    <= '0;
      acc_wdata_q   <= '0;
      owner_spi_q   <= 1'b0;
      last_spi_q    <= 1'b0;
      ovf_q         <= 1'b0;
      tx_data_q     <= '0;
      host_rdata_q  <= '0;
      tx_valid_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      pend_q        <= pend_d;
      pend_we_q     <= pend_we_d;
      pend_addr_q   <= pend_addr_d;
      pend_wdata_q  <= pend_wdata_d;
      acc_we_q      <= acc_we_d;
      acc_addr_q    <= acc_addr_d;
      acc_wdata_q   <= acc_wdata_d;
      owner_spi_q   <= owner_spi_d;
      last_spi_q    <= last_spi_d;
      ovf_q         <= ovf_d;
      tx_data_q     <= tx_data_d;
      host_rdata_q  <= host_rdata_d;
      tx_valid_q    <= tx_valid_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign spi_ovf     = ovf_q;

endmodule
